text_pixel_generator: RTL and testbench

- Consumes the 800x600@72 timing generator's strobes and text coordinates, and produces the VGA pixel colour.
- Text grid is 100x60 cells; each cell is 8x10 pixels.
- Per cell, the block:
  - reads a {attribute, character} word from text RAM;
  - reads the matching glyph row from font ROM;
  - serialises that row into 1-bit RGB with foreground/background, underline and blink.
- hsync/vsync are delayed to stay aligned with the registered pixel output.

---
 rtl/text_pixel_generator.sv | 159 +++++++++++++++
 tb/tb_text_pixel_generator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_generator.sv
// Text-mode pixel generator: fetches cell word and glyph row per 8-pixel cell,
// then serialises them into 1-bit RGB with underline, blink and delayed syncs.
module text_pixel_generator #(
  parameter int TEXT_COLS   = 100,
  parameter int TEXT_ROWS   = 60,
  parameter int CHAR_HEIGHT = 10,
  parameter int BLINK_BITS  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        drawing,
  input  logic        clk_load_char,
  input  logic        clk_load_design,
  input  logic        clk_draw_char,
  input  logic [6:0]  xtext,
  input  logic [5:0]  ytext,
  input  logic [3:0]  scanline,
  output logic [12:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [12:0] COLS_W  = 13'(TEXT_COLS);
  localparam logic [12:0] ROWS_W  = 13'(TEXT_ROWS);
  localparam logic [3:0]  UL_LINE = 4'(CHAR_HEIGHT - 1);

  logic [12:0]           addr_s;
  logic [7:0]            pend_attr_r;
  logic [7:0]            pend_pattern_r;
  logic                  design_d1_r;
  logic                  design_d2_r;
  logic [7:0]            shift_r;
  logic [7:0]            cur_attr_r;
  logic                  cur_underline_r;
  logic                  vsync_prev_r;
  logic [BLINK_BITS-1:0] frame_cnt_r;

  logic       pat_bit_s;
  logic [7:0] attr_s;
  logic       ul_line_s;
  logic [2:0] fg_s;
  logic [2:0] bg_s;
  logic       on_s;
  logic [2:0] colour_s;

  // Cell address; coordinates outside the grid fall back to address 0
  always_comb begin
    addr_s = 13'd0;
    if (({7'd0, ytext} < ROWS_W) && ({6'd0, xtext} < COLS_W)) begin
      addr_s = ({7'd0, ytext} * COLS_W) + {6'd0, xtext};
    end else begin
      addr_s = 13'd0;
    end
  end

  // Fetch pipeline: font_addr takes the character straight from the RAM word
  // so the glyph lookup always belongs to the cell just read
  always_ff @(posedge clk) begin
    if (reset) begin
      text_addr      <= 13'd0;
      font_addr      <= 12'd0;
      pend_attr_r    <= 8'd0;
      pend_pattern_r <= 8'd0;
      design_d1_r    <= 1'b0;
      design_d2_r    <= 1'b0;
    end else begin
      if (clk_load_char) begin
        text_addr <= addr_s;
      end
      if (clk_load_design) begin
        pend_attr_r <= text_data[15:8];
        font_addr   <= {text_data[7:0], scanline};
      end
      design_d1_r <= clk_load_design;
      design_d2_r <= design_d1_r;
      if (design_d2_r) begin
        pend_pattern_r <= font_data;
      end
    end
  end

  // Shifter: bit 7 of the new pattern is emitted in the draw cycle itself,
  // so the register is loaded already advanced by one pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r         <= 8'd0;
      cur_attr_r      <= 8'd0;
      cur_underline_r <= 1'b0;
    end else if (clk_draw_char) begin
      shift_r         <= {pend_pattern_r[6:0], 1'b0};
      cur_attr_r      <= pend_attr_r;
      cur_underline_r <= (scanline == UL_LINE);
    end else begin
      shift_r <= {shift_r[6:0], 1'b0};
    end
  end

  // Pixel colour selection
  always_comb begin
    pat_bit_s = shift_r[7];
    attr_s    = cur_attr_r;
    ul_line_s = cur_underline_r;
    if (clk_draw_char) begin
      pat_bit_s = pend_pattern_r[7];
      attr_s    = pend_attr_r;
      ul_line_s = (scanline == UL_LINE);
    end else begin
      pat_bit_s = shift_r[7];
      attr_s    = cur_attr_r;
      ul_line_s = cur_underline_r;
    end
    bg_s = attr_s[5:3];
    if (attr_s[7] && frame_cnt_r[BLINK_BITS-1]) begin
      fg_s = attr_s[5:3];
    end else begin
      fg_s = attr_s[2:0];
    end
    on_s = pat_bit_s | (attr_s[6] & ul_line_s);
    if (on_s) begin
      colour_s = fg_s;
    end else begin
      colour_s = bg_s;
    end
  end

  // Output register, sync delay and frame counter on vsync falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      red          <= 1'b0;
      green        <= 1'b0;
      blue         <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      vsync_prev_r <= 1'b1;
      frame_cnt_r  <= '0;
    end else begin
      if (drawing) begin
        {red, green, blue} <= colour_s;
      end else begin
        {red, green, blue} <= 3'b000;
      end
      hsync        <= hsync_in;
      vsync        <= vsync_in;
      vsync_prev_r <= vsync_in;
      if (vsync_prev_r && !vsync_in) begin
        frame_cnt_r <= frame_cnt_r + {{(BLINK_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_generator.sv
// Directed bench for text_pixel_generator: pixel expectations go into a
// scoreboard queue and a negedge monitor pops them as pixels emerge.
module tb_text_pixel_generator;

  logic        clk = 1'b0;
  logic        reset, hsync_in, vsync_in, drawing;
  logic        clk_load_char, clk_load_design, clk_draw_char;
  logic [6:0]  xtext;
  logic [5:0]  ytext;
  logic [3:0]  scanline;
  logic [12:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        red, green, blue, hsync, vsync;

  logic [15:0] tram [0:8191];
  logic [7:0]  from [0:4095];
  logic [2:0]  exp_q [$];
  logic        draw_d = 1'b0;
  int          win = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  text_pixel_generator dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .drawing(drawing), .clk_load_char(clk_load_char),
    .clk_load_design(clk_load_design), .clk_draw_char(clk_draw_char),
    .xtext(xtext), .ytext(ytext), .scanline(scanline),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #10 clk = ~clk;

  // Synchronous-read memory models, 1-cycle latency
  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_data <= from[font_addr];
    draw_d    <= clk_draw_char;
  end

  // Monitor: 8 pixels appear after each draw strobe
  always @(negedge clk) begin
    logic [2:0] e;
    if (draw_d) win = 8;
    if (win > 0) begin
      win = win - 1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pixel: got rgb=%b with no expected entry queued", {red, green, blue});
      end else begin
        e = exp_q.pop_front();
        if ({red, green, blue} !== e) begin
          n_bad++;
          $display("FAIL pixel: got rgb=%b expected %b", {red, green, blue}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pix(input logic [23:0] pix);
    for (int i = 7; i >= 0; i--) exp_q.push_back(pix[i*3 +: 3]);
  endtask

  // One full load/design/draw sequence followed by the 8 pixel cycles
  task automatic do_cell(input logic [6:0] x, input logic [5:0] y, input logic [3:0] sl,
                         input logic drw, input logic [12:0] exp_addr,
                         input logic [11:0] exp_font, input logic [23:0] pix);
    xtext = x; ytext = y; scanline = sl; drawing = drw;
    clk_load_char = 1'b1;
    tick();
    clk_load_char = 1'b0;
    check("text_addr", {3'd0, text_addr}, {3'd0, exp_addr});
    tick();
    clk_load_design = 1'b1;
    tick();
    clk_load_design = 1'b0;
    check("font_addr", {4'd0, font_addr}, {4'd0, exp_font});
    repeat (4) tick();
    push_pix(pix);
    clk_draw_char = 1'b1;
    tick();
    clk_draw_char = 1'b0;
    repeat (8) tick();
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b0;
      tick();
      vsync_in = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [1:0] hv;
    for (int i = 0; i < 8192; i++) tram[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) from[i] = 8'h00;
    tram[305]  = 16'h1F41;
    tram[5999] = 16'h4742;
    tram[100]  = 16'h4742;
    tram[10]   = 16'h9F41;
    from[12'h412] = 8'b1010_0000;

    reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; drawing = 1'b1;
    clk_load_char = 1'b0; clk_load_design = 1'b0; clk_draw_char = 1'b0;
    xtext = 7'd0; ytext = 6'd0; scanline = 4'd0;
    repeat (3) tick();
    check("reset_rgb", {13'd0, red, green, blue}, 16'h0000);
    check("reset_hsync", {15'd0, hsync}, 16'h0001);
    check("reset_vsync", {15'd0, vsync}, 16'h0001);
    hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Partial cell, then reset mid-line
    xtext = 7'd5; ytext = 6'd3; scanline = 4'd2;
    clk_load_char = 1'b1; tick(); clk_load_char = 1'b0;
    tick();
    clk_load_design = 1'b1; tick(); clk_load_design = 1'b0;
    repeat (3) tick();
    reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    check("midreset_rgb", {13'd0, red, green, blue}, 16'h0000);
    check("midreset_hsync", {15'd0, hsync}, 16'h0001);
    check("midreset_vsync", {15'd0, vsync}, 16'h0001);
    check("midreset_text_addr", {3'd0, text_addr}, 16'h0000);
    check("midreset_font_addr", {4'd0, font_addr}, 16'h0000);
    hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    // Draw with no post-reset load: pipeline was cleared, so black
    push_pix(24'h000000);
    clk_draw_char = 1'b1; tick(); clk_draw_char = 1'b0;
    repeat (8) tick();

    do_cell(7'd5, 6'd3, 4'd2, 1'b1, 13'd305, 12'h412,
            {3'd7, 3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3});
    do_cell(7'd99, 6'd59, 4'd9, 1'b1, 13'd5999, 12'h429,
            {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7});
    do_cell(7'd0, 6'd1, 4'd8, 1'b1, 13'd100, 12'h428, 24'h000000);

    vs_edges(32);
    do_cell(7'd10, 6'd0, 4'd2, 1'b1, 13'd10, 12'h412,
            {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3});
    vs_edges(32);
    do_cell(7'd10, 6'd0, 4'd2, 1'b1, 13'd10, 12'h412,
            {3'd7, 3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3});

    do_cell(7'd5, 6'd3, 4'd2, 1'b0, 13'd305, 12'h412, 24'h000000);

    // Sync delay: outputs follow inputs by one cycle
    for (int i = 0; i < 4; i++) begin
      hv = i[1:0];
      hsync_in = hv[1]; vsync_in = hv[0];
      tick();
      check("hsync_delay", {15'd0, hsync}, {15'd0, hv[1]});
      check("vsync_delay", {15'd0, vsync}, {15'd0, hv[0]});
    end
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) tick();

    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
